multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback.
//  Drives IR/PC/regfile enables, ALU and writeback muxes, and the imem/dmem req/ack handshakes.
//  Classifies the IR opcode (instr_i[6:2]), which also feeds the immediate generator.
//  Raises a sticky trap on illegal instructions, ECALL/EBREAK or memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a req may wait for ack before trapping (>=2)
// PORTS
//  clk_i        in   1   core clock, single clock domain
//  rst_i        in   1   synchronous, active-high reset
//  instr_i      in   32  current IR contents
//  br_taken_i   in   1   branch comparator result, valid in EXEC
//  imem_ack_i   in   1   instruction memory ack, rdata valid this cycle
//  dmem_ack_i   in   1   data memory ack (load data valid / store done)
//  imem_req_o   out  1   instruction fetch request
//  dmem_req_o   out  1   data memory request
//  dmem_we_o    out  1   1=store, 0=load; valid with dmem_req_o
//  ir_we_o      out  1   load IR from imem rdata
//  pc_we_o      out  1   update PC
//  pc_sel_o     out  2   0=PC+4 1=PC+imm 2=(rs1+imm)&~1
//  alu_a_sel_o  out  1   0=rs1 1=PC
//  alu_b_sel_o  out  1   0=rs2 1=imm
//  rf_we_o      out  1   regfile write enable
//  wb_sel_o     out  2   0=ALU 1=load data 2=PC+4
//  trap_o       out  1   sticky trap flag
//  cause_o      out  2   0=none 1=illegal 2=ecall/ebreak 3=mem timeout
//  instret_o    out  32  retired-instruction counter
// BEHAVIOUR
//  - Reset: state=FETCH, timeout cnt=0, instret_o=0, trap_o=0, cause_o=0.
//    All outputs are 0 while rst_i=1. imem_req_o=1 in the first cycle after rst_i falls.
//    Reset at any point aborts the instruction. No partial PC/RF write may occur in that cycle.
//  - FETCH: hold imem_req_o=1 until imem_ack_i. In the ack cycle: ir_we_o=1, next state DECODE.
//  - DECODE (1 cycle): trap illegal (cause 1) if instr_i[1:0]!=2'b11 or the opcode is not an RV32I class.
//    SYSTEM traps with cause 2. Otherwise go to EXEC.
//  - EXEC (1 cycle): drive alu_a/b_sel per class.
//    LUI/AUIPC/JAL use a=PC, b=imm. OP uses b=rs2.
//    LOAD/STORE go to MEM.
//    BRANCH: pc_we_o=1, pc_sel=br_taken_i?1:0, retire, go to FETCH.
//    MISC-MEM (FENCE) is a NOP: pc_we_o=1, pc_sel=0, retire, go to FETCH.
//    All other classes go to WB.
//  - MEM: hold dmem_req_o=1, with dmem_we_o=1 for STORE, until dmem_ack_i.
//    On ack, LOAD goes to WB.
//    On ack, STORE asserts pc_we_o=1 (pc_sel=0), retires, and goes to FETCH.
//  - WB (1 cycle): rf_we_o=1 only if instr_i[11:7]!=0.
//    wb_sel: LOAD=1, JAL/JALR=2, else 0.
//    pc_we_o=1 with pc_sel: JAL=1, JALR=2, else 0. Retire, go to FETCH.
//  - Retire means instret_o+1 on the next edge. It wraps 0xFFFFFFFF->0.
//  - Timeout: a counter clears on entry to FETCH/MEM and increments each waiting cycle.
//    If no ack within MEM_TIMEOUT cycles of req, go to TRAP with cause 3.
//    An ack in the same cycle the limit is reached wins: no trap.
//  - TRAP: all req/we outputs 0, trap_o=1, cause_o held. Only rst_i exits TRAP.
//  - ir_we_o/pc_we_o/rf_we_o pulse exactly 1 cycle per instruction. Ack-driven strobes are combinational on ack.
//  - Latency, with 0-wait memory:
//    ALU/JAL/JALR = 4 cycles, BRANCH = 3, LOAD = 5, STORE = 4.
// STRUCTURE
//  - Opcode encodings come from the shared OPCODE_* constants.
//  - Package cpu_ctrl_pkg holds:
//    state_e {FETCH,DECODE,EXEC,MEM,WB,TRAP}, instr_class_e, and the pc_sel/wb_sel/cause enums.
//  - Sub-module ctrl_decode: combinational instr_i -> instr_class_e + legal flag. Shared by DECODE, EXEC and WB.
// TESTING
//  1. Reset: hold rst_i 3 cycles mid-MEM -> all outputs 0; next cycle imem_req_o=1, instret_o=0.
//  2. addi x1,x0,5 (0x00500093), ack same cycle -> ir_we@1, EXEC b_sel=1, WB rf_we=1 wb_sel=0 pc_sel=0; instret_o=1.
//  3. beq taken (0x00000463, br_taken_i=1) -> pc_we_o=1 pc_sel=1 in EXEC, no rf_we_o, back to FETCH.
//  4. lw x2,0(x1) (0x0000A103) with dmem_ack after 3 waits -> dmem_req 4 cycles, dmem_we_o=0, then WB wb_sel=1 rf_we=1.
//  5. Illegal 0x00000000 -> TRAP, cause_o=1, trap_o sticky for 20 cycles with no reqs.
//     ecall 0x00000073 -> cause_o=2.
//  6. imem_ack never arrives -> trap_o=1, cause_o=3 after 16 cycles. Ack on the 16th cycle -> no trap.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control path:
// opcode encodings (instr[6:2]), FSM states, instruction classes and the
// encodings of the PC-select, writeback-select and trap-cause outputs.
package cpu_ctrl_pkg;

    // RV32I major opcodes, bits [6:2] of the instruction word
    localparam logic [4:0] OPCODE_LOAD     = 5'b00000;
    localparam logic [4:0] OPCODE_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPCODE_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC    = 5'b00101;
    localparam logic [4:0] OPCODE_STORE    = 5'b01000;
    localparam logic [4:0] OPCODE_OP       = 5'b01100;
    localparam logic [4:0] OPCODE_LUI      = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH   = 5'b11000;
    localparam logic [4:0] OPCODE_JALR     = 5'b11001;
    localparam logic [4:0] OPCODE_JAL      = 5'b11011;
    localparam logic [4:0] OPCODE_SYSTEM   = 5'b11100;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_ILLEGAL  = 4'd0,
        CLS_LUI      = 4'd1,
        CLS_AUIPC    = 4'd2,
        CLS_JAL      = 4'd3,
        CLS_JALR     = 4'd4,
        CLS_BRANCH   = 4'd5,
        CLS_LOAD     = 4'd6,
        CLS_STORE    = 4'd7,
        CLS_OP_IMM   = 4'd8,
        CLS_OP       = 4'd9,
        CLS_MISC_MEM = 4'd10,
        CLS_SYSTEM   = 4'd11
    } instr_class_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JALR   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_ECALL   = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } cause_e;

    // ALU operand A is the PC for the PC-relative / upper-immediate classes
    function automatic logic alu_a_is_pc(input instr_class_e cls);
        logic sel;
        case (cls)
            CLS_LUI, CLS_AUIPC, CLS_JAL: sel = 1'b1;
            default:                     sel = 1'b0;
        endcase
        return sel;
    endfunction

    // ALU operand B is the immediate for everything except reg-reg, compare and FENCE
    function automatic logic alu_b_is_imm(input instr_class_e cls);
        logic sel;
        case (cls)
            CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
            CLS_LOAD, CLS_STORE, CLS_OP_IMM: sel = 1'b1;
            default:                         sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: maps the IR to an instruction class and
// flags encodings that are not RV32I (bad length bits or unknown opcode).
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0]  instr_i,
    output instr_class_e class_o,
    output logic         legal_o
);

    // Only the opcode field is inspected here; the rest belongs to the datapath
    logic unused_instr_s;
    assign unused_instr_s = ^instr_i[31:7];

    // Map major opcode to its class; anything unrecognised is illegal
    always_comb begin
        class_o = CLS_ILLEGAL;
        case (instr_i[6:2])
            OPCODE_LUI:      class_o = CLS_LUI;
            OPCODE_AUIPC:    class_o = CLS_AUIPC;
            OPCODE_JAL:      class_o = CLS_JAL;
            OPCODE_JALR:     class_o = CLS_JALR;
            OPCODE_BRANCH:   class_o = CLS_BRANCH;
            OPCODE_LOAD:     class_o = CLS_LOAD;
            OPCODE_STORE:    class_o = CLS_STORE;
            OPCODE_OP_IMM:   class_o = CLS_OP_IMM;
            OPCODE_OP:       class_o = CLS_OP;
            OPCODE_MISC_MEM: class_o = CLS_MISC_MEM;
            OPCODE_SYSTEM:   class_o = CLS_SYSTEM;
            default:         class_o = CLS_ILLEGAL;
        endcase
    end

    assign legal_o = (instr_i[1:0] == 2'b11) && (class_o != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Strobes that depend on a memory ack are combinational on that ack so the
// datapath captures data in the ack cycle. Illegal opcodes, ECALL/EBREAK and
// memory-ack timeouts park the FSM in a sticky TRAP state left only by reset.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        br_taken_i,
    input  logic        imem_ack_i,
    input  logic        dmem_ack_i,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic        alu_a_sel_o,
    output logic        alu_b_sel_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        trap_o,
    output logic [1:0]  cause_o,
    output logic [31:0] instret_o
);

    localparam int              CNT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      instret_q, instret_d;
    logic             trap_q, trap_d;
    cause_e           cause_q, cause_d;

    instr_class_e     cls_s;
    logic             legal_s;
    logic             retire_s;
    logic             limit_s;
    pc_sel_e          pc_sel_s;
    wb_sel_e          wb_sel_s;

    ctrl_decode u_decode (
        .instr_i (instr_i),
        .class_o (cls_s),
        .legal_o (legal_s)
    );

    // The current wait cycle is the last one allowed for the pending ack
    assign limit_s = (cnt_q == CNT_LIMIT);

    // State, timeout counter, retire counter and sticky trap registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= FETCH;
            cnt_q     <= CNT_ZERO;
            instret_q <= 32'd0;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state logic, trap capture, wait counter and retire count
    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        case (state_q)
            FETCH: begin
                if (imem_ack_i) begin
                    state_d = DECODE;
                end else if (limit_s) begin
                    state_d = TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                if (!legal_s) begin
                    state_d = TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else if (cls_s == CLS_SYSTEM) begin
                    state_d = TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ECALL;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (cls_s)
                    CLS_LOAD, CLS_STORE:      state_d = MEM;
                    CLS_BRANCH, CLS_MISC_MEM: state_d = FETCH;
                    default:                  state_d = WB;
                endcase
            end
            MEM: begin
                if (dmem_ack_i) begin
                    state_d = (cls_s == CLS_LOAD) ? WB : FETCH;
                end else if (limit_s) begin
                    state_d = TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    state_d = MEM;
                end
            end
            WB:      state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase

        // Counter restarts on every state change and counts only while waiting
        if (state_d != state_q) begin
            cnt_d = CNT_ZERO;
        end else if ((state_q == FETCH) || (state_q == MEM)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = CNT_ZERO;
        end

        if (retire_s) begin
            instret_d = instret_q + 32'd1;
        end else begin
            instret_d = instret_q;
        end
    end

    // Output decode per state; everything is forced low while reset is held
    always_comb begin
        imem_req_o  = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_s    = PC_PLUS4;
        alu_a_sel_o = 1'b0;
        alu_b_sel_o = 1'b0;
        rf_we_o     = 1'b0;
        wb_sel_s    = WB_ALU;
        retire_s    = 1'b0;
        if (rst_i) begin
            retire_s = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    imem_req_o = 1'b1;
                    ir_we_o    = imem_ack_i;
                end
                EXEC: begin
                    alu_a_sel_o = alu_a_is_pc(cls_s);
                    alu_b_sel_o = alu_b_is_imm(cls_s);
                    if (cls_s == CLS_BRANCH) begin
                        pc_we_o  = 1'b1;
                        pc_sel_s = br_taken_i ? PC_BRANCH : PC_PLUS4;
                        retire_s = 1'b1;
                    end else if (cls_s == CLS_MISC_MEM) begin
                        pc_we_o  = 1'b1;
                        retire_s = 1'b1;
                    end else begin
                        retire_s = 1'b0;
                    end
                end
                MEM: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = (cls_s == CLS_STORE);
                    if (dmem_ack_i && (cls_s == CLS_STORE)) begin
                        pc_we_o  = 1'b1;
                        retire_s = 1'b1;
                    end else begin
                        retire_s = 1'b0;
                    end
                end
                WB: begin
                    rf_we_o  = (instr_i[11:7] != 5'd0);
                    pc_we_o  = 1'b1;
                    retire_s = 1'b1;
                    case (cls_s)
                        CLS_LOAD: wb_sel_s = WB_LOAD;
                        CLS_JAL: begin
                            wb_sel_s = WB_PC4;
                            pc_sel_s = PC_BRANCH;
                        end
                        CLS_JALR: begin
                            wb_sel_s = WB_PC4;
                            pc_sel_s = PC_JALR;
                        end
                        default:  wb_sel_s = WB_ALU;
                    endcase
                end
                default: begin
                    retire_s = 1'b0;
                end
            endcase
        end
    end

    assign pc_sel_o  = pc_sel_s;
    assign wb_sel_o  = wb_sel_s;
    assign trap_o    = trap_q & ~rst_i;
    assign cause_o   = rst_i ? 2'd0 : cause_q;
    assign instret_o = rst_i ? 32'd0 : instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Each instruction is expanded at the
// transaction level into the cycle-by-cycle output vectors it must produce
// (from the class rules and the chosen ack delays); a compare process checks
// the DUT against that expected stream on every cycle.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic        imem_req;
        logic        dmem_req;
        logic        dmem_we;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic        a_sel;
        logic        b_sel;
        logic        rf_we;
        logic [1:0]  wb_sel;
        logic        trap;
        logic [1:0]  cause;
        logic [31:0] instret;
    } out_t;

    logic        clk;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        br_taken_i, imem_ack_i, dmem_ack_i;
    logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o;
    logic [1:0]  pc_sel_o, wb_sel_o, cause_o;
    logic        alu_a_sel_o, alu_b_sel_o, rf_we_o, trap_o;
    logic [31:0] instret_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    out_t exp_q[$];

    // Model state
    int          m_instret = 0;
    logic        m_trap    = 1'b0;
    logic [1:0]  m_cause   = 2'd0;
    logic [31:0] cur_instr = 32'd0;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .instr_i     (instr_i),
        .br_taken_i  (br_taken_i),
        .imem_ack_i  (imem_ack_i),
        .dmem_ack_i  (dmem_ack_i),
        .imem_req_o  (imem_req_o),
        .dmem_req_o  (dmem_req_o),
        .dmem_we_o   (dmem_we_o),
        .ir_we_o     (ir_we_o),
        .pc_we_o     (pc_we_o),
        .pc_sel_o    (pc_sel_o),
        .alu_a_sel_o (alu_a_sel_o),
        .alu_b_sel_o (alu_b_sel_o),
        .rf_we_o     (rf_we_o),
        .wb_sel_o    (wb_sel_o),
        .trap_o      (trap_o),
        .cause_o     (cause_o),
        .instret_o   (instret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t base();
        out_t e;
        e         = '0;
        e.trap    = m_trap;
        e.cause   = m_cause;
        e.instret = 32'(m_instret);
        return e;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs after the edge, queue the expected outputs
    task automatic cycle(input logic r, input logic ia, input logic da, input logic bt,
                         input out_t e);
        @(posedge clk);
        #1;
        rst_i      = r;
        imem_ack_i = ia;
        dmem_ack_i = da;
        br_taken_i = bt;
        instr_i    = cur_instr;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        m_instret = 0;
        m_trap    = 1'b0;
        m_cause   = 2'd0;
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, out_t'(0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, i[0], ~i[0], 1'b0, base());
    endtask

    // Expand one instruction into its expected cycle sequence
    task automatic run_instr(input logic [31:0] ins, input logic br, input int iwait,
                             input int dwait, input int stop_mem, output int ncyc);
        out_t e;
        logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_fence, is_sys;
        logic legal, a_pc, b_imm;
        is_lui   = (ins[6:0] == 7'b0110111);
        is_auipc = (ins[6:0] == 7'b0010111);
        is_jal   = (ins[6:0] == 7'b1101111);
        is_jalr  = (ins[6:0] == 7'b1100111);
        is_br    = (ins[6:0] == 7'b1100011);
        is_ld    = (ins[6:0] == 7'b0000011);
        is_st    = (ins[6:0] == 7'b0100011);
        is_opi   = (ins[6:0] == 7'b0010011);
        is_op    = (ins[6:0] == 7'b0110011);
        is_fence = (ins[6:0] == 7'b0001111);
        is_sys   = (ins[6:0] == 7'b1110011);
        legal = is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st |
                is_opi | is_op | is_fence | is_sys;
        a_pc  = is_lui | is_auipc | is_jal;
        b_imm = ~(is_op | is_br | is_fence);
        ncyc  = 0;
        // Fetch: waits, then the ack cycle loads IR
        for (int k = 0; k < iwait && k < 16; k++) begin
            e = base(); e.imem_req = 1'b1;
            cycle(1'b0, 1'b0, 1'b0, 1'b0, e); ncyc++;
        end
        if (iwait >= 16) begin m_trap = 1'b1; m_cause = 2'd3; return; end
        e = base(); e.imem_req = 1'b1; e.ir_we = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, e); ncyc++;
        cur_instr = ins;
        // Decode: no visible activity
        cycle(1'b0, 1'b0, 1'b0, 1'b0, base()); ncyc++;
        if (!legal) begin m_trap = 1'b1; m_cause = 2'd1; return; end
        if (is_sys) begin m_trap = 1'b1; m_cause = 2'd2; return; end
        // Execute
        e = base(); e.a_sel = a_pc; e.b_sel = b_imm;
        if (is_br || is_fence) begin
            e.pc_we = 1'b1; e.pc_sel = (is_br && br) ? 2'd1 : 2'd0;
        end
        cycle(1'b0, 1'b0, 1'b0, br, e); ncyc++;
        if (is_br || is_fence) begin m_instret++; return; end
        // Memory
        if (is_ld || is_st) begin
            for (int k = 0; k < dwait && k < 16; k++) begin
                if (stop_mem > 0 && k >= stop_mem) return;
                e = base(); e.dmem_req = 1'b1; e.dmem_we = is_st;
                cycle(1'b0, 1'b0, 1'b0, 1'b0, e); ncyc++;
            end
            if (stop_mem > 0) return;
            if (dwait >= 16) begin m_trap = 1'b1; m_cause = 2'd3; return; end
            e = base(); e.dmem_req = 1'b1; e.dmem_we = is_st; e.pc_we = is_st;
            cycle(1'b0, 1'b0, 1'b1, 1'b0, e); ncyc++;
            if (is_st) begin m_instret++; return; end
        end
        // Writeback
        e = base();
        e.rf_we  = (ins[11:7] != 5'd0);
        e.wb_sel = is_ld ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        e.pc_we  = 1'b1;
        e.pc_sel = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, e); ncyc++;
        m_instret++;
    endtask

    // Compare the DUT against the expected stream every cycle, away from the edge
    initial begin
        out_t e, a;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{imem_req: imem_req_o, dmem_req: dmem_req_o, dmem_we: dmem_we_o,
                      ir_we: ir_we_o, pc_we: pc_we_o, pc_sel: pc_sel_o, a_sel: alu_a_sel_o,
                      b_sel: alu_b_sel_o, rf_we: rf_we_o, wb_sel: wb_sel_o, trap: trap_o,
                      cause: cause_o, instret: instret_o};
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL outputs cycle %0d: got %h expected %h (req/dreq/we/ir/pc/psel/a/b/rf/wsel/trap/cause/instret)",
                             cyc, a, e);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        int n;
        rst_i = 1'b1; instr_i = 32'd0; br_taken_i = 1'b0;
        imem_ack_i = 1'b0; dmem_ack_i = 1'b0;

        do_reset(2);
        // Abort a load while it waits in MEM, then reset for 3 cycles
        run_instr(32'h0000A103, 1'b0, 0, 10, 2, n);
        do_reset(3);

        run_instr(32'h00500093, 1'b0, 0, 0, 0, n);  check32("addi latency", 32'(n), 32'd4);
        run_instr(32'h00000463, 1'b1, 0, 0, 0, n);  check32("beq latency", 32'(n), 32'd3);
        run_instr(32'h0000A103, 1'b0, 0, 3, 0, n);  check32("lw 3-wait latency", 32'(n), 32'd8);
        run_instr(32'h0020A223, 1'b0, 0, 0, 0, n);  check32("sw latency", 32'(n), 32'd4);
        run_instr(32'h008000EF, 1'b0, 0, 0, 0, n);  check32("jal latency", 32'(n), 32'd4);
        run_instr(32'h00008067, 1'b0, 0, 0, 0, n);
        run_instr(32'h000012B7, 1'b0, 0, 0, 0, n);
        run_instr(32'h00001297, 1'b0, 0, 0, 0, n);
        run_instr(32'h002081B3, 1'b0, 0, 0, 0, n);
        run_instr(32'h0000000F, 1'b0, 0, 0, 0, n);  check32("fence latency", 32'(n), 32'd3);
        run_instr(32'h00000463, 1'b0, 0, 0, 0, n);
        // imem ack on the 16th waiting cycle must not trap
        run_instr(32'h00500093, 1'b0, 15, 0, 0, n); check32("ack at limit latency", 32'(n), 32'd19);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '{imem_req: 1'b1, instret: 32'(m_instret), default: '0});
        @(negedge clk);
        check32("instret after 12", instret_o, 32'd12);
        check32("no trap after 12", {31'd0, trap_o}, 32'd0);

        // Illegal all-zero word: sticky trap, cause 1, no requests
        run_instr(32'h00000000, 1'b0, 0, 0, 0, n);
        idle(20);
        @(negedge clk);
        check32("illegal cause", {30'd0, cause_o}, 32'd1);
        check32("illegal trap", {31'd0, trap_o}, 32'd1);

        do_reset(2);
        run_instr(32'h00000073, 1'b0, 0, 0, 0, n);
        idle(3);
        @(negedge clk);
        check32("ecall cause", {30'd0, cause_o}, 32'd2);

        do_reset(2);
        run_instr(32'h00500093, 1'b0, 16, 0, 0, n);
        idle(3);
        @(negedge clk);
        check32("imem timeout cause", {30'd0, cause_o}, 32'd3);

        do_reset(1);
        run_instr(32'h0020A223, 1'b0, 0, 16, 0, n);
        idle(2);
        do_reset(1);
        run_instr(32'h00500090, 1'b0, 0, 0, 0, n);
        idle(2);
        do_reset(1);
        run_instr(32'h0000007F, 1'b0, 0, 0, 0, n);
        idle(2);
        do_reset(2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '{imem_req: 1'b1, default: '0});
        @(negedge clk);
        check32("instret after reset", instret_o, 32'd0);

        @(posedge clk);
        @(negedge clk);
        check32("expected stream drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
